// File: rtl/poly_vec_addsub_if.sv
// Beat-level handshake bundle for poly_vec_addsub: input operand stream,
// result stream with framing flags, and the sticky operand-range flag.
interface poly_vec_addsub_if #(
    parameter int LANES = 4
) ();
    logic [1:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic [32*LANES-1:0] in_a;
    logic [32*LANES-1:0] in_b;
    logic                out_valid;
    logic                out_ready;
    logic [32*LANES-1:0] out_c;
    logic                out_last_poly;
    logic                out_last;
    logic                range_err;

    modport master (
        output mode, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_last_poly, out_last, range_err
    );

    modport slave (
        input  mode, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_last_poly, out_last, range_err
    );
endinterface

// File: rtl/poly_vec_addsub.sv
// Two-stage streaming coefficient add/sub over frames of K polynomials,
// with raw 32-bit wrap or mod-Q reduced modes latched per frame.
module poly_vec_addsub #(
    parameter int LANES = 4,
    parameter int N     = 256,
    parameter int K     = 4,
    parameter int Q     = 8380417
) (
    input logic              clk,
    input logic              rst,
    poly_vec_addsub_if.slave bus
);
    localparam int          PB    = N / LANES;
    localparam int          BEATS = K * PB;
    localparam int          CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0] PB_U  = 32'(PB);
    localparam logic signed [32:0] QS = 33'(Q);

    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_SUB   = 2'b01,
        MODE_ADD_Q = 2'b10,
        MODE_SUB_Q = 2'b11
    } mode_e;

    logic                advance, accept, out_fire, lane_bad;
    logic [CW-1:0]       in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    mode_e               mode_q, mode_d, beat_mode;
    logic                range_err_q, range_err_d;
    logic signed [32:0]  a_x [LANES];
    logic signed [32:0]  b_x [LANES];
    logic signed [32:0]  s1_r_d [LANES];
    logic signed [32:0]  s1_r_q [LANES];
    mode_e               s1_mode_q;
    logic                s1_valid_q;
    logic                s2_valid_q;
    logic [32*LANES-1:0] s2_c_d, s2_c_q;

    // Both stages move together whenever the output register can be refilled.
    assign advance  = !s2_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && advance;
    assign out_fire = s2_valid_q && bus.out_ready;
    assign beat_mode = (in_cnt_q == '0) ? mode_e'(bus.mode) : mode_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        mode_d      = mode_q;
        lane_bad    = 1'b0;
        range_err_d = range_err_q;
        if (accept) begin
            in_cnt_d = (in_cnt_q == CW'(BEATS - 1)) ? '0 : in_cnt_q + CW'(1);
            mode_d   = beat_mode;
        end
        if (out_fire)
            out_cnt_d = (out_cnt_q == CW'(BEATS - 1)) ? '0 : out_cnt_q + CW'(1);
        for (int i = 0; i < LANES; i++) begin
            a_x[i]    = {bus.in_a[32*i+31], bus.in_a[32*i +: 32]};
            b_x[i]    = {bus.in_b[32*i+31], bus.in_b[32*i +: 32]};
            s1_r_d[i] = beat_mode[0] ? a_x[i] - b_x[i] : a_x[i] + b_x[i];
            if (a_x[i][32] || a_x[i] >= QS || b_x[i][32] || b_x[i] >= QS)
                lane_bad = 1'b1;
        end
        if (accept && beat_mode[1] && lane_bad)
            range_err_d = 1'b1;
    end

    // Single conditional correction brings an in-range sum/difference into [0, Q).
    always_comb begin
        s2_c_d = '0;
        for (int i = 0; i < LANES; i++) begin
            case (s1_mode_q)
                MODE_ADD_Q: s2_c_d[32*i +: 32] = (s1_r_q[i] >= QS) ? 32'(s1_r_q[i] - QS)
                                                                  : s1_r_q[i][31:0];
                MODE_SUB_Q: s2_c_d[32*i +: 32] = s1_r_q[i][32] ? 32'(s1_r_q[i] + QS)
                                                               : s1_r_q[i][31:0];
                default:    s2_c_d[32*i +: 32] = s1_r_q[i][31:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so each register samples its neighbours' pre-edge values.
        if (rst) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            mode_q      <= MODE_ADD;
            range_err_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_c_q      <= '0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            mode_q      <= mode_d;
            range_err_q <= range_err_d;
            if (advance) begin
                s1_valid_q <= bus.in_valid;
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q)
                    s2_c_q <= s2_c_d;
            end
        end
    end

    // NOTE: S1 payload is not reset; s1_valid_q gates every use of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_r_q    <= s1_r_d;
            s1_mode_q <= beat_mode;
        end
    end

    assign bus.in_ready      = advance;
    assign bus.out_valid     = s2_valid_q;
    assign bus.out_c         = s2_c_q;
    assign bus.out_last_poly = s2_valid_q && ((32'(out_cnt_q) % PB_U) == PB_U - 32'd1);
    assign bus.out_last      = s2_valid_q && (out_cnt_q == CW'(BEATS - 1));
    assign bus.range_err     = range_err_q;
endmodule

// File: tb/tb_poly_vec_addsub.sv
// Randomised scoreboard bench for poly_vec_addsub: a longint reference model
// predicts every result beat and its framing flags.
module tb_poly_vec_addsub;
    localparam int L     = 4;
    localparam int N     = 256;
    localparam int K     = 4;
    localparam int Q     = 8380417;
    localparam int W     = 32 * L;
    localparam int PB    = N / L;
    localparam int BEATS = K * PB;

    typedef struct {
        logic [W-1:0] c;
        logic         lp;
        logic         l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   m_idx = 0;
    logic [1:0] m_mode = 2'b00;
    logic m_err = 1'b0;
    logic bp_stop = 1'b0;

    poly_vec_addsub_if #(.LANES(L)) bus ();

    poly_vec_addsub #(.LANES(L), .N(N), .K(K), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_lane(input logic [1:0] m, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = m[0] ? sa - sb : sa + sb;
        if (m == 2'b10 && r >= Q) r = r - Q;
        if (m == 2'b11 && r < 0)  r = r + Q;
        return r[31:0];
    endfunction

    // Reference: a frame's mode is whatever was offered with its first beat.
    task automatic model_push(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb;
        if (m_idx == 0) m_mode = m;
        for (int i = 0; i < L; i++) begin
            e.c[32*i +: 32] = ref_lane(m_mode, a[32*i +: 32], b[32*i +: 32]);
            sa = longint'($signed(a[32*i +: 32]));
            sb = longint'($signed(b[32*i +: 32]));
            if (m_mode[1] && (sa < 0 || sa >= Q || sb < 0 || sb >= Q)) m_err = 1'b1;
        end
        e.lp = (m_idx % PB) == PB - 1;
        e.l  = m_idx == BEATS - 1;
        exp_q.push_back(e);
        m_idx = (m_idx + 1) % BEATS;
    endtask

    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        int   waited;
        acc = 1'b0;
        waited = 0;
        bus.mode = m;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        while (!acc && waited <= 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (acc) model_push(m, a, b);
        else begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got no accept in %0d cycles expected accept", waited);
        end
    endtask

    task automatic send_all(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        send(m, {L{a}}, {L{b}});
    endtask

    function automatic logic [W-1:0] gen(input logic in_range);
        logic [W-1:0] v;
        for (int i = 0; i < L; i++)
            v[32*i +: 32] = in_range ? 32'($urandom_range(Q - 1, 0)) : $urandom;
        return v;
    endfunction

    task automatic send_frame(input logic [1:0] m_first, input logic [1:0] m_after,
                              input int switch_at, input int bad_beat, input int nbeats);
        logic [W-1:0] a, b;
        for (int i = 0; i < nbeats; i++) begin
            a = gen(m_first[1]);
            b = gen(m_first[1]);
            if (i == bad_beat) a[32*2 +: 32] = 32'(Q);
            send((i < switch_at) ? m_first : m_after, a, b);
        end
    endtask

    task automatic send_frame_bp(input logic [1:0] m);
        bp_stop = 1'b0;
        fork
            begin
                send_frame(m, m, BEATS, -1, BEATS);
                bp_stop = 1'b1;
            end
            begin
                while (!bp_stop) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(3, 0) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", W'(exp_q.size()), W'(0));
    endtask

    task automatic reset_dut();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_idx  = 0;
        m_mode = 2'b00;
        m_err  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got beat %0h expected none", bus.out_c);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_c", bus.out_c, mon_e.c);
                check("out_last_poly", W'(bus.out_last_poly), W'(mon_e.lp));
                check("out_last", W'(bus.out_last), W'(mon_e.l));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] c0;
        bus.mode = 2'b00;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_dut();
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_c", bus.out_c, W'(0));
        check("rst_out_last_poly", W'(bus.out_last_poly), W'(0));
        check("rst_out_last", W'(bus.out_last), W'(0));
        check("rst_range_err", W'(bus.range_err), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));

        // Directed reduced add, with pipeline fill observed on out_valid.
        @(posedge clk);
        #1;
        send_all(2'b10, 32'd8380416, 32'd1);
        @(negedge clk);
        check("lat_not_yet_valid", W'(bus.out_valid), W'(0));
        @(negedge clk);
        check("lat_out_valid", W'(bus.out_valid), W'(1));
        send_all(2'b10, 32'd4190208, 32'd4190208);
        drain();
        reset_dut();
        send_all(2'b11, 32'd0, 32'd1);
        send_all(2'b11, 32'd5, 32'd3);
        drain();
        reset_dut();
        send_all(2'b01, 32'd0, 32'd1);
        drain();
        reset_dut();
        send_all(2'b00, 32'h7FFF_FFFF, 32'd1);
        drain();
        check("directed_range_err", W'(bus.range_err), W'(m_err));

        // Two back-to-back frames: beat 256 restarts framing under a new mode.
        reset_dut();
        send_frame(2'b00, 2'b00, BEATS, -1, BEATS);
        send_frame(2'b10, 2'b10, BEATS, -1, BEATS);
        drain();

        // Fixed stall mid-frame: outputs frozen and input blocked.
        fork
            send_frame(2'b11, 2'b11, BEATS, -1, BEATS);
            begin
                repeat (60) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                c0 = bus.out_c;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_out_valid", W'(bus.out_valid), W'(1));
                    check("stall_out_c", bus.out_c, c0);
                    check("stall_in_ready", W'(bus.in_ready), W'(0));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        send_frame_bp(2'b01);
        drain();

        // Mode offered mid-frame must not take effect until the next frame.
        send_frame(2'b10, 2'b01, 10, -1, BEATS);
        drain();
        check("latch_range_err", W'(bus.range_err), W'(m_err));

        send_frame(2'b10, 2'b10, BEATS, 0, BEATS);
        drain();
        check("range_err_set", W'(bus.range_err), W'(m_err));
        send_frame(2'b00, 2'b00, BEATS, -1, BEATS);
        drain();
        check("range_err_sticky", W'(bus.range_err), W'(m_err));

        // Reset with beats in flight, then a fresh frame under random backpressure.
        send_frame(2'b11, 2'b11, BEATS, -1, 40);
        reset_dut();
        @(negedge clk);
        check("midrst_out_valid", W'(bus.out_valid), W'(0));
        check("midrst_range_err", W'(bus.range_err), W'(0));
        check("midrst_out_c", bus.out_c, W'(0));
        @(posedge clk);
        #1;
        send_frame_bp(2'b10);
        drain();
        check("final_range_err", W'(bus.range_err), W'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
